// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
// Latency: none, this file holds declarations only.
// Backpressure: none, this file holds declarations only.
package dmem_responder_pkg;

    localparam int DATA_W      = 16;
    localparam int DEF_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with synchronous write and a registered read port.
// Latency: write commits at the strobed edge; rdata updates one edge after rd_stb.
// Backpressure: none; the caller never strobes read and write together.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_stb,
    input  logic              rd_stb,
    input  logic [ADDR_W-1:0] idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Read data only moves on a read strobe, otherwise it holds the last capture.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_stb) begin
            rdata_d = mem[idx];
        end
    end

    // Read register clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Storage survives reset; the caller already suppresses writes while rst is high.
    always_ff @(posedge clk) begin
        if (wr_stb) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for a stalling pipeline; option macro DMEM_POSTED_WR_EN posts writes.
// Latency: LATENCY cycles from acceptance to the single-cycle DONE slot (posted writes commit at once).
// Backpressure: stall is held while an access is outstanding; requests outside IDLE are ignored.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int ADDR_W  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dm_rd_en,
    input  logic        dm_wr_en,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        rd_valid,
    output logic        stall,
    output logic        err
);

`ifdef DMEM_POSTED_WR_EN
    localparam bit POSTED_WR = 1'b1;
`else
    localparam bit POSTED_WR = 1'b0;
`endif

    // Counter value seen in the final BUSY cycle; unused when LATENCY is 1.
    localparam logic [3:0] LAST_CNT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam bit         SINGLE   = (LATENCY == 1);

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                op_wr_q, op_wr_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic                in_idle;
    logic                accept;
    logic                posted;
    logic                full_acc;
    logic                busy_last;
    logic                arr_wr;
    logic                arr_rd;
    logic [ADDR_W-1:0]   arr_idx;
    logic [DATA_W-1:0]   arr_wdata;
    logic                unused_addr;

    // Only the word-index bits of the byte address matter.
    assign unused_addr = ^addr;

    // Request decode, storage port steering and the combinational handshake outputs.
    always_comb begin
        in_idle   = (state_q == IDLE);
        accept    = in_idle & (dm_rd_en ^ dm_wr_en) & ~rst;
        posted    = accept & dm_wr_en & POSTED_WR;
        full_acc  = accept & ~posted;
        busy_last = (state_q == BUSY) && (cnt_q == LAST_CNT);

        // In IDLE the storage sees the live request (single-cycle or posted case),
        // later it sees the request latched at acceptance.
        arr_idx   = in_idle ? addr[ADDR_W:1] : idx_q;
        arr_wdata = in_idle ? wdata : wdata_q;

        arr_wr = ~rst & (posted
                         | (full_acc & dm_wr_en & SINGLE)
                         | (busy_last & op_wr_q));
        arr_rd = ~rst & ((full_acc & dm_rd_en & SINGLE)
                         | (busy_last & ~op_wr_q));

        stall    = ~rst & (full_acc | (state_q == BUSY));
        err      = ~rst & in_idle & dm_rd_en & dm_wr_en;
        rd_valid = ~rst & (state_q == DONE) & ~op_wr_q;
    end

    // Next-state logic: accept in IDLE, count through BUSY, one DONE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_wr_d = op_wr_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (full_acc) begin
                    op_wr_d = dm_wr_en;
                    idx_d   = addr[ADDR_W:1];
                    wdata_d = wdata;
                    cnt_d   = 4'd0;
                    state_d = SINGLE ? DONE : BUSY;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control state; reset abandons any access in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_wr_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_wr_q <= op_wr_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .wr_stb (arr_wr),
        .rd_stb (arr_rd),
        .idx    (arr_idx),
        .wdata  (arr_wdata),
        .rdata  (rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: three responders (LATENCY 4, 1, 15) driven one at a time.
// Reads push the expected word and due cycle; per-unit monitors pop on rd_valid.
// The reference memory is a plain array updated at issue, since accesses never overlap.
module tb_dmem_responder;

`ifdef DMEM_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst      [3];
    logic        rd_en    [3];
    logic        wr_en    [3];
    logic [15:0] addr     [3];
    logic [15:0] wdata    [3];
    logic [15:0] rdata_o  [3];
    logic        rd_valid_o [3];
    logic        stall_o  [3];
    logic        err_o    [3];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          mon_en = 1'b0;
    logic [15:0] hold [3];
    logic [15:0] mdl  [3][32];
    exp_t        q0[$], q1[$], q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int u);
        return (u == 0) ? 4 : (u == 1) ? 1 : 15;
    endfunction

    task automatic chk(input string nm, input int u, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s unit%0d cyc=%0d got=%0h exp=%0h", nm, u, cyc, got, exp);
        end
    endtask

    function automatic void push(input int u, input exp_t e);
        case (u)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic void clear(input int u);
        case (u)
            0: q0.delete();
            1: q1.delete();
            default: q2.delete();
        endcase
    endfunction

    function automatic int qsize(input int u);
        case (u)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(input int u);
        case (u)
            0: return q0.pop_front();
            1: return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Monitor: every rd_valid must match the head of the queue; otherwise rdata holds.
    task automatic mon(input int u);
        exp_t e;
        if (rst[u]) return;
        if (rd_valid_o[u]) begin
            if (qsize(u) == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_valid_unexpected unit%0d cyc=%0d got=1 exp=0", u, cyc);
            end else begin
                e = pop(u);
                chk("rdata", u, 32'(rdata_o[u]), 32'(e.d));
                chk("rd_cycle", u, cyc, e.c);
                hold[u] = e.d;
            end
        end else begin
            chk("rdata_hold", u, 32'(rdata_o[u]), 32'(hold[u]));
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_u
        dmem_responder #(
            .LATENCY ((g == 0) ? 4 : (g == 1) ? 1 : 15),
            .ADDR_W  (10)
        ) dut (
            .clk      (clk),
            .rst      (rst[g]),
            .dm_rd_en (rd_en[g]),
            .dm_wr_en (wr_en[g]),
            .addr     (addr[g]),
            .wdata    (wdata[g]),
            .rdata    (rdata_o[g]),
            .rd_valid (rd_valid_o[g]),
            .stall    (stall_o[g]),
            .err      (err_o[g])
        );
        always @(negedge clk) if (mon_en) mon(g);
    end

    // Byte address for word w with random junk in addr[0] and the ignored upper bits.
    function automatic logic [15:0] mk_addr(input int w);
        logic [15:0] a;
        a       = 16'($urandom_range(0, 65535));
        a[10:1] = 10'(w);
        return a;
    endfunction

    // One legal access; controls stay asserted through DONE like a frozen pipeline.
    task automatic op(input int u, input bit isw, input logic [15:0] a, input logic [15:0] d);
        int   L;
        int   t;
        int   w;
        exp_t e;
        L = lat_of(u);
        w = int'(a[5:1]);
        @(negedge clk);
        rd_en[u] = !isw;
        wr_en[u] = isw;
        addr[u]  = a;
        wdata[u] = d;
        t = cyc;
        #1;
        chk("err_on_accept", u, 32'(err_o[u]), 0);
        if (isw && POSTED) begin
            chk("stall_posted", u, 32'(stall_o[u]), 0);
            mdl[u][w] = d;
        end else begin
            if (isw) begin
                mdl[u][w] = d;
            end else begin
                e.d = mdl[u][w];
                e.c = t + L;
                push(u, e);
            end
            chk("stall_T", u, 32'(stall_o[u]), 1);
            for (int k = 1; k < L; k++) begin
                @(negedge clk);
                #1;
                chk("stall_busy", u, 32'(stall_o[u]), 1);
            end
            @(negedge clk);
            #1;
            chk("stall_done", u, 32'(stall_o[u]), 0);
        end
    endtask

    task automatic idle(input int u, input int n);
        repeat (n) begin
            @(negedge clk);
            rd_en[u] = 1'b0;
            wr_en[u] = 1'b0;
            #1;
            chk("stall_idle", u, 32'(stall_o[u]), 0);
        end
    endtask

    task automatic illegal(input int u, input logic [15:0] a);
        @(negedge clk);
        rd_en[u] = 1'b1;
        wr_en[u] = 1'b1;
        addr[u]  = a;
        wdata[u] = 16'($urandom_range(0, 65535));
        #1;
        chk("err_both", u, 32'(err_o[u]), 1);
        chk("stall_both", u, 32'(stall_o[u]), 0);
        @(negedge clk);
        rd_en[u] = 1'b0;
        wr_en[u] = 1'b0;
        #1;
        chk("err_pulse_end", u, 32'(err_o[u]), 0);
    endtask

    task automatic preload(input int u);
        for (int w = 0; w < 32; w++) begin
            op(u, 1'b1, mk_addr(w), 16'($urandom_range(0, 65535)));
        end
    endtask

    task automatic random_ops(input int u, input int n);
        int r;
        int w;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            w = $urandom_range(0, 31);
            if (r < 4)       op(u, 1'b0, mk_addr(w), 16'($urandom_range(0, 65535)));
            else if (r < 8)  op(u, 1'b1, mk_addr(w), 16'($urandom_range(0, 65535)));
            else if (r == 8) illegal(u, mk_addr(w));
            else             idle(u, $urandom_range(1, 2));
        end
        idle(u, lat_of(u) + 2);
        chk("queue_drained", u, qsize(u), 0);
    endtask

    // Write aborted by a reset pulse two cycles after acceptance.
    task automatic reset_abort(input int u);
        @(negedge clk);
        rd_en[u] = 1'b0;
        wr_en[u] = 1'b1;
        addr[u]  = 16'h0020;
        wdata[u] = 16'h1234;
        #1;
        chk("abort_stall_T", u, 32'(stall_o[u]), POSTED ? 0 : 1);
        if (POSTED) mdl[u][16] = 16'h1234;
        @(negedge clk);
        #1;
        chk("abort_stall_T1", u, 32'(stall_o[u]), POSTED ? 0 : 1);
        @(negedge clk);
        rst[u]  = 1'b1;
        hold[u] = 16'h0000;
        clear(u);
        #1;
        chk("stall_in_rst", u, 32'(stall_o[u]), 0);
        @(negedge clk);
        rst[u]   = 1'b0;
        wr_en[u] = 1'b0;
        #1;
        chk("stall_after_rst", u, 32'(stall_o[u]), 0);
        chk("rd_valid_after_rst", u, 32'(rd_valid_o[u]), 0);
        chk("rdata_after_rst", u, 32'(rdata_o[u]), 0);
        op(u, 1'b0, 16'h0020, 16'h0000);
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u]   = 1'b1;
            rd_en[u] = 1'b1;
            wr_en[u] = 1'b0;
            addr[u]  = 16'h0;
            wdata[u] = 16'h0;
            hold[u]  = 16'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            chk("rst_stall", u, 32'(stall_o[u]), 0);
            chk("rst_rd_valid", u, 32'(rd_valid_o[u]), 0);
            chk("rst_err", u, 32'(err_o[u]), 0);
            chk("rst_rdata", u, 32'(rdata_o[u]), 0);
        end
        mon_en = 1'b1;
        for (int u = 0; u < 3; u++) begin
            rst[u]   = 1'b0;
            rd_en[u] = 1'b0;
        end

        // Unit 0, LATENCY 4: directed cases then random traffic.
        preload(0);
        idle(0, 1);
        op(0, 1'b1, 16'h0010, 16'hBEEF);
        op(0, 1'b0, 16'h0010, 16'h0000);
        idle(0, 1);
        illegal(0, 16'h0010);
        op(0, 1'b0, 16'h0010, 16'h0000);
        reset_abort(0);
        op(0, 1'b1, 16'h0030, 16'h00A5);
        op(0, 1'b0, 16'h0030, 16'h0000);
        random_ops(0, 60);

        // Unit 1, LATENCY 1: back-to-back reads, then random traffic.
        preload(1);
        op(1, 1'b0, 16'h0002, 16'h0000);
        op(1, 1'b0, 16'h0004, 16'h0000);
        illegal(1, 16'h0004);
        random_ops(1, 60);

        // Unit 2, LATENCY 15: longest counter run.
        preload(2);
        random_ops(2, 20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 4: cycles from request acceptance to completion; legal range 1..15.
REQ-002 Parameter ADDR_W, default 10: word-address bits of internal storage, giving 2^ADDR_W 16-bit words.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 dm_rd_en  in  1  read request from the pipeline data-memory stage.
REQ-006 dm_wr_en  in  1  write request from the pipeline data-memory stage.
REQ-007 addr  in  16  byte address; word index = addr[ADDR_W:1]; addr[0] and the upper bits are ignored.
REQ-008 wdata  in  16  store data, sampled at acceptance.
REQ-009 rdata  out  16  read data, valid only while rd_valid=1.
REQ-010 rd_valid  out  1  one-cycle pulse marking read completion.
REQ-011 stall  out  1  pipeline freeze request while an access is outstanding.
REQ-012 err  out  1  one-cycle pulse flagging an illegal request.

Function
REQ-013 FSM states IDLE, BUSY, DONE; a 4-bit counter cnt tracks BUSY progress.
REQ-014 IDLE with exactly one of dm_rd_en/dm_wr_en high accepts the request at cycle T: latch op, word index and wdata; set cnt=0.
REQ-015 stall is combinational and high in cycle T; it stays high through cycle T+LATENCY-1.
REQ-016 IDLE->BUSY on acceptance when LATENCY>1; BUSY increments cnt each cycle; BUSY->DONE at the edge where cnt==LATENCY-2.
REQ-017 When LATENCY==1, IDLE->DONE directly at the end of cycle T.
REQ-018 A write commits to storage at the edge ending cycle T+LATENCY-1; a read captures storage into rdata at the same edge.
REQ-019 DONE lasts exactly one cycle (T+LATENCY) with stall=0; rd_valid=1 only for reads; then DONE->IDLE unconditionally.
REQ-020 Requests seen in BUSY or DONE are ignored, because the pipeline holds its controls until it advances; the earliest next acceptance is T+LATENCY+1.
REQ-021 dm_rd_en and dm_wr_en both high in IDLE: no acceptance, no storage change, stall=0, err=1 for that cycle.
REQ-022 rdata holds its last captured value outside rd_valid; rd_valid and err are never high in BUSY.
REQ-023 A read of a word written by the previous completed write returns the new data.

Reset
REQ-024 rst=1 at an edge forces state=IDLE, cnt=0, rdata=0, rd_valid=0, err=0; stall reads 0 while rst is high.
REQ-025 rst asserted in BUSY or DONE abandons the access: an uncommitted write is discarded and no rd_valid is issued.
REQ-026 Storage contents are not cleared by reset.

Configuration
REQ-027 Macro DMEM_POSTED_WR_EN defined: a write in IDLE commits at the edge ending cycle T, stall=0 in T, and the state remains IDLE; reads are unchanged.
REQ-028 DMEM_POSTED_WR_EN undefined: writes follow the full LATENCY timing of REQ-014..REQ-019.

Structure
REQ-029 The shared package holds the state enum typedef (IDLE/BUSY/DONE), the data width constant 16, and the default LATENCY constant.
REQ-030 Storage is a sub-module, dmem_array: single port, synchronous write, rdata registered on a read strobe; the FSM and counter stay in dmem_responder.

Verification
REQ-031 LATENCY=4, macro off, write addr=0x0010 wdata=0xBEEF at T -> stall high T..T+3, low at T+4, no rd_valid.
REQ-032 Then read addr=0x0010 at T' -> stall high T'..T'+3, rd_valid=1 and rdata=0xBEEF at T'+4 only.
REQ-033 dm_rd_en=dm_wr_en=1 in IDLE -> err=1 one cycle, stall=0; a following read of the target word returns its prior value.
REQ-034 Write 0x1234 to addr=0x0020, with rst pulsed at T+2 -> stall=0 and state IDLE after reset; a later read of addr=0x0020 returns the pre-write value.
REQ-035 LATENCY=1, back-to-back reads of 0x0002 then 0x0004 -> accepted at T and T+2, rd_valid at T+1 and T+3, stall high only in T and T+2.
REQ-036 Macro on, write addr=0x0030 wdata=0x00A5 at T, then read addr=0x0030 at T+1 -> stall=0 at T, rdata=0x00A5 with rd_valid at T+1+LATENCY.
